gate_stim_checker: RTL and testbench

Stimulus generator and checker that drives the two inputs of a two-input lab gate and verifies its output. It walks a, b through the full truth table (00, 01, 10, 11) and samples the gate result against the expected value for a selected function. It counts mismatches and signals completion. It sits directly upstream of the gate under test (feeds `a`, `b`) and consumes its output `c`, replacing free-running toggle stimulus with a deterministic, self-checking sequence.

---
 rtl/gate_stim_pkg.sv | 21 ++
 rtl/gate_stim_checker_if.sv | 28 ++
 rtl/gate_ref_model.sv | 22 ++
 rtl/gate_stim_checker.sv | 130 +++++++++++++
 tb/tb_gate_stim_checker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/gate_stim_pkg.sv
// Shared types and constants for the gate stimulus/checker block and its benches.
// Optional feature macro used by the bundle: GATE_STIM_LOOP_EN.
package gate_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FUNC_AND  = 2'd0,
    FUNC_OR   = 2'd1,
    FUNC_XOR  = 2'd2,
    FUNC_NAND = 2'd3
  } func_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/gate_stim_checker_if.sv
// Handshake/bus bundle between the stimulus checker (master) and its environment (slave).
// The loop input exists only when GATE_STIM_LOOP_EN is defined.
interface gate_stim_checker_if;
  import gate_stim_pkg::*;

  logic             start;
  logic             gate_out;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             expected;
  logic [ERR_W-1:0] err_count;
`ifdef GATE_STIM_LOOP_EN
  logic             loop;

  modport master (input start, gate_out, loop,
                  output a, b, busy, done, expected, err_count);
  modport slave  (output start, gate_out, loop,
                  input a, b, busy, done, expected, err_count);
`else
  modport master (input start, gate_out,
                  output a, b, busy, done, expected, err_count);
  modport slave  (output start, gate_out,
                  input a, b, busy, done, expected, err_count);
`endif

endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input gate; shared by the checker and benches.
module gate_ref_model
  import gate_stim_pkg::*;
(
  input  func_e func_i,
  input  logic  a_i,
  input  logic  b_i,
  output logic  expected_o
);

  always_comb begin
    expected_o = 1'b0;
    case (func_i)
      FUNC_AND:  expected_o = a_i & b_i;
      FUNC_OR:   expected_o = a_i | b_i;
      FUNC_XOR:  expected_o = a_i ^ b_i;
      FUNC_NAND: expected_o = ~(a_i & b_i);
      default:   expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Walks a/b through the truth table, checks the gate output on the last hold cycle
// of each vector and counts mismatches. GATE_STIM_LOOP_EN enables back-to-back runs.
module gate_stim_checker
  import gate_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_PASSES  = 1,
  parameter int FUNC        = 1
) (
  input  logic                clock,
  input  logic                reset,
  gate_stim_checker_if.master bus
);

  localparam int              HOLD_W    = 8;
  localparam int              PASS_W    = 4;
  localparam func_e           FUNC_SEL  = func_e'(FUNC[1:0]);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

  state_e             state_q;
  logic [1:0]         v_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [PASS_W-1:0]  pass_q;
  logic [ERR_W-1:0]   err_q;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;

  logic               expected_w;
  logic               last_hold;
  logic               last_vec;
  logic               mismatch;
  logic               loop_req;
  logic [1:0]         v_d;
  logic [ERR_W-1:0]   err_d;

  gate_ref_model u_ref (
    .func_i     (FUNC_SEL),
    .a_i        (a_q),
    .b_i        (b_q),
    .expected_o (expected_w)
  );

`ifdef GATE_STIM_LOOP_EN
  assign loop_req = bus.loop;
`else
  assign loop_req = 1'b0;
`endif

  assign last_hold = (hold_q == HOLD_LAST);
  assign last_vec  = (v_q == 2'd3) && (pass_q == PASS_LAST);
  assign mismatch  = (bus.gate_out != expected_w);
  assign v_d       = v_q + 2'd1;
  // Saturate instead of wrapping so a badly broken gate never reads as clean.
  assign err_d     = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      hold_q  <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            err_q   <= '0;
            v_q     <= '0;
            hold_q  <= '0;
            pass_q  <= '0;
          end
        end
        RUN: begin
          if (last_hold) begin
            hold_q <= '0;
            err_q  <= err_d;
            if (last_vec) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              v_q        <= '0;
              {a_q, b_q} <= 2'b00;
            end else begin
              v_q        <= v_d;
              {a_q, b_q} <= v_d;
              if (v_q == 2'd3) pass_q <= pass_q + 1'b1;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          // Looping keeps err_q so the count accumulates across runs.
          if (loop_req) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            v_q     <= '0;
            hold_q  <= '0;
            pass_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.expected  = expected_w;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench: OR-configured checker with OR/AND gate, and NAND-configured
// checker with a stuck-at-0 (or inverted) gate; loop tests need GATE_STIM_LOOP_EN.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  logic rst;
  logic use_and;
  logic inv_b;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  gate_stim_checker_if ia ();
  gate_stim_checker_if ib ();

  assign ia.gate_out = use_and ? (ia.a & ia.b) : (ia.a | ia.b);
  assign ib.gate_out = inv_b ? ~ib.expected : 1'b0;

  gate_stim_checker #(.HOLD_CYCLES(2), .NUM_PASSES(1), .FUNC(1)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ia.master)
  );

  gate_stim_checker #(.HOLD_CYCLES(1), .NUM_PASSES(15), .FUNC(3)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ib.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full run of dut_a; err_mid/err_end are the counts after vector 01 / 10 checks.
  task automatic run_a(input string name, input int err_mid, input int err_end, input bit poke_start);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ia.start = (poke_start && i == 2);
      chk({name, "_ab"},   {30'd0, ia.a, ia.b}, i / 2);
      chk({name, "_exp"},  ia.expected, (i / 2) != 0);
      chk({name, "_busy"}, ia.busy, 1);
      chk({name, "_done"}, ia.done, 0);
      chk({name, "_err"},  ia.err_count, (i < 4) ? 0 : (i < 6) ? err_mid : err_end);
      @(negedge clk);
    end
    ia.start = 1'b0;
    chk({name, "_done_pulse"}, ia.done, 1);
    chk({name, "_done_busy"},  ia.busy, 0);
    chk({name, "_done_ab"},    {30'd0, ia.a, ia.b}, 0);
    chk({name, "_done_err"},   ia.err_count, err_end);
    @(negedge clk);
    chk({name, "_idle_done"},  ia.done, 0);
    chk({name, "_idle_busy"},  ia.busy, 0);
    chk({name, "_hold_err"},   ia.err_count, err_end);
    $display("run %s: err_count=%0d", name, ia.err_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    int  k;
    rst      = 1'b1;
    use_and  = 1'b0;
    inv_b    = 1'b0;
    ia.start = 1'b0;
    ib.start = 1'b0;
`ifdef GATE_STIM_LOOP_EN
    ia.loop  = 1'b0;
    ib.loop  = 1'b0;
`endif
    repeat (2) @(negedge clk);

    chk("rst_a_ab",   {30'd0, ia.a, ia.b}, 0);
    chk("rst_a_busy", ia.busy, 0);
    chk("rst_a_done", ia.done, 0);
    chk("rst_a_err",  ia.err_count, 0);
    chk("rst_a_exp",  ia.expected, 0);
    chk("rst_b_exp",  ib.expected, 1);
    rst = 1'b0;
    @(negedge clk);

    run_a("or_gate", 0, 0, 1'b0);
    use_and = 1'b1;
    run_a("and_gate", 1, 2, 1'b1);

    // NAND checker, gate stuck at 0: 00/01/10 mismatch each pass.
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 80; c++) begin
      if (ib.done) begin
        seen = 1;
        chk("b_done_cycle", c, 61);
        chk("b_done_err",   ib.err_count, 45);
        chk("b_done_busy",  ib.busy, 0);
        break;
      end
      chk("b_busy", ib.busy, 1);
      if (c <= 9) begin
        chk("b_ab",  {30'd0, ib.a, ib.b}, (c - 1) % 4);
        chk("b_err", ib.err_count, 3 * ((c - 1) / 4) + ((c - 1) % 4));
      end
      @(negedge clk);
    end
    if (seen == 0) chk("b_done_seen", 0, 1);
    @(negedge clk);
    chk("b_idle_done", ib.done, 0);
    chk("b_hold_err",  ib.err_count, 45);
    $display("run nand_stuck0: err_count=%0d", ib.err_count);

    // Reset during vector 10 of pass 0 with one mismatch already counted.
    use_and  = 1'b1;
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_ab",  {30'd0, ia.a, ia.b}, 2);
    chk("pre_rst_err", ia.err_count, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ab",   {30'd0, ia.a, ia.b}, 0);
    chk("mid_rst_busy", ia.busy, 0);
    chk("mid_rst_done", ia.done, 0);
    chk("mid_rst_err",  ia.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_done", ia.done, 0);
      chk("post_rst_busy", ia.busy, 0);
    end
    $display("run reset_abort: err_count=%0d", ia.err_count);
    use_and = 1'b0;
    run_a("after_reset", 0, 0, 1'b0);

`ifdef GATE_STIM_LOOP_EN
    // Looping correct gate: done every 9 cycles, busy low only on done.
    ia.loop  = 1'b1;
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      chk("loop_done", ia.done, (c <= 36) && (c % 9 == 0));
      chk("loop_busy", ia.busy, (c <= 36) && (c % 9 != 0));
      if (c == 30) ia.loop = 1'b0;
      @(negedge clk);
    end
    chk("loop_err", ia.err_count, 0);
    $display("run loop_or: err_count=%0d", ia.err_count);

    // Looping inverted gate: 60 mismatches per run until saturation.
    inv_b    = 1'b1;
    ib.loop  = 1'b1;
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    k = 0;
    for (int c = 1; c <= 500; c++) begin
      if (ib.done) begin
        k++;
        chk("sat_err", ib.err_count, (60 * k > 255) ? 255 : 60 * k);
        if (k == 6) begin
          ib.loop = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    chk("sat_runs", k, 6);
    @(negedge clk);
    chk("sat_idle_busy", ib.busy, 0);
    chk("sat_hold_err",  ib.err_count, 255);
    $display("run loop_saturate: err_count=%0d", ib.err_count);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
